// File: rtl/ysyx_25020047_lsu_axi_bridge.sv
// LSU-to-AXI4-Lite bridge: one load or store at a time, answered with a
// single-cycle response pulse carrying read data and an error flag.
module ysyx_25020047_lsu_axi_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,

  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,

  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                aw_done, w_done;
  logic                aw_fin, w_fin;
  logic                accept, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  assign accept = req_valid & req_ready;
  assign ar_hs  = arvalid & arready;
  assign r_hs   = rvalid & rready;
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_wen ? WRITE : RADDR;
      RADDR:   if (ar_hs) state_nxt = RDATA;
      RDATA:   if (r_hs) state_nxt = IDLE;
      WRITE:   if (aw_fin && w_fin) state_nxt = WRESP;
      WRESP:   if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Valid/ready decode only from flops, so no input reaches them combinationally.
  always_comb begin
    req_ready = (state == IDLE);
    arvalid   = (state == RADDR);
    rready    = (state == RDATA);
    awvalid   = (state == WRITE) && !aw_done;
    wvalid    = (state == WRITE) && !w_done;
    bready    = (state == WRESP);
  end

  // Per-channel completion; cleared whenever WRITE is not the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= (state_nxt == WRITE) && aw_fin;
      w_done  <= (state_nxt == WRITE) && w_fin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= r_hs | b_hs;
      if (r_hs) begin
        resp_rdata <= rdata;
        resp_err   <= (rresp != 2'b00);
      end else if (b_hs) begin
        resp_err   <= (bresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu_axi_bridge.sv
// Directed bench for the LSU AXI4-Lite bridge: vector table with a
// delay-programmable slave, plus back-to-back and mid-transaction reset cases.
module tb_ysyx_25020047_lsu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_25020047_lsu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  xresp;
    int          a_dly;
    int          w_dly;
    int          r_dly;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; bvalid = 1'b0; rdata = '0; rresp = '0; bresp = '0;
  endtask

  // Slave readies rise after their valid has been seen for *_dly cycles.
  task automatic run_txn(input vec_t v);
    int lat = -1;
    int a_hi = 0, w_hi = 0, stab = 0, rr_bad = 0;
    int a_seen = 0, w_seen = 0, r_seen = 0;
    int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 1'b0; req_wen = ~v.wen; req_addr = 32'hFFFF_FFFF;
      req_wdata = ~v.wdata; req_wstrb = ~v.wstrb;
      if (resp_valid) begin
        lat = c;
        break;
      end
      if (req_ready) rr_bad++;
      if (arvalid) begin a_hi++; if (araddr !== v.addr) stab++; end
      if (awvalid) begin a_hi++; if (awaddr !== v.addr) stab++; end
      if (wvalid) begin
        w_hi++;
        if (wdata !== v.wdata || wstrb !== v.wstrb) stab++;
      end
      arready = arvalid && (a_seen >= v.a_dly);
      awready = awvalid && (a_seen >= v.a_dly);
      if (arvalid || awvalid) a_seen++;
      wready = wvalid && (w_seen >= v.w_dly);
      if (wvalid) w_seen++;
      rvalid = rready && (r_seen >= v.r_dly);
      bvalid = bready && (r_seen >= v.r_dly);
      if (rready || bready) r_seen++;
      rdata = rvalid ? v.rdata : 32'h0BAD_0BAD;
      rresp = v.xresp;
      bresp = v.xresp;
      if (arvalid && arready) n_ar++;
      if (rvalid && rready)   n_r++;
      if (awvalid && awready) n_aw++;
      if (wvalid && wready)   n_w++;
      if (bvalid && bready)   n_b++;
    end
    clear_slave();
    chk("latency", lat, v.exp_lat);
    chk("resp_rdata", resp_rdata, v.exp_rdata);
    chk("resp_err", {31'd0, resp_err}, {31'd0, v.exp_err});
    chk("req_ready_in_resp", {31'd0, req_ready}, 32'd1);
    chk("handshakes", n_ar * 10000 + n_r * 1000 + n_aw * 100 + n_w * 10 + n_b,
        v.wen ? 32'd111 : 32'd11000);
    chk("addr_valid_cycles", a_hi, v.a_dly + 1);
    chk("wvalid_cycles", w_hi, v.wen ? v.w_dly + 1 : 0);
    chk("payload_stable", stab, 0);
    chk("req_ready_busy", rr_bad, 0);
    @(negedge clk);
    chk("resp_pulse_single", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    //           wen  addr           wdata          wstrb  rdata          xr     a  w  r  lat exp_rdata      err
    tbl[0] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 3, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b1, 32'h8000_0010, 32'h0000_AB00, 4'h2, 32'h0,         2'b00, 3, 0, 0, 6, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00, 2, 0, 0, 5, 32'hDEAD_BEEF, 1'b0};
    tbl[3] = '{1'b1, 32'h8000_0024, 32'h5566_0000, 4'hC, 32'h0,         2'b00, 0, 4, 0, 7, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{1'b1, 32'h8000_0028, 32'h0,         4'h0, 32'h0,         2'b00, 1, 1, 0, 4, 32'hDEAD_BEEF, 1'b0};
    tbl[5] = '{1'b0, 32'h8000_0030, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b10, 2, 0, 1, 6, 32'hCAFE_F00D, 1'b1};
    tbl[6] = '{1'b1, 32'h8000_0034, 32'h0000_00A5, 4'h1, 32'h0,         2'b11, 0, 0, 2, 5, 32'hCAFE_F00D, 1'b1};
    tbl[7] = '{1'b0, 32'h8000_0008, 32'h0,         4'h0, 32'h0123_4567, 2'b00, 0, 0, 0, 3, 32'h0123_4567, 1'b0};
    tbl[8] = '{1'b0, 32'h8000_0040, 32'h0,         4'h0, 32'h89AB_CDEF, 2'b00, 1, 0, 0, 4, 32'h89AB_CDEF, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_regs", araddr | awaddr | wdata | {28'd0, wstrb}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Back-to-back: load then store, req_valid held high throughout.
    @(negedge clk);
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0050;
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h8000_0054; req_wdata = 32'hA5A5_5A5A; req_wstrb = 4'hF;
    chk("b2b_c1", {27'd0, req_ready, arvalid, awvalid, wvalid, resp_valid}, 32'b01000);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h1357_9BDF;
    chk("b2b_c2", {27'd0, req_ready, rready, awvalid, wvalid, resp_valid}, 32'b01000);
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    chk("b2b_c3", {28'd0, req_ready, awvalid, wvalid, resp_valid}, 32'b1001);
    chk("b2b_load_rdata", resp_rdata, 32'h1357_9BDF);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_c4", {27'd0, req_ready, awvalid, wvalid, bready, resp_valid}, 32'b01100);
    chk("b2b_store_addr", awaddr, 32'h8000_0054);
    @(negedge clk);
    bvalid = 1'b1; bresp = 2'b00;
    chk("b2b_c5", {28'd0, req_ready, awvalid, bready, resp_valid}, 32'b0010);
    @(negedge clk);
    bvalid = 1'b0;
    chk("b2b_c6", {29'd0, req_ready, resp_valid, resp_err}, 32'b110);
    clear_slave();

    // Reset asserted while waiting in RDATA.
    @(negedge clk);
    arready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0060;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    arready = 1'b0;
    chk("pre_rst_rready", {31'd0, rready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valids", {28'd0, rready, arvalid, resp_valid, req_ready}, 32'b0001);
    chk("async_rst_rdata", resp_rdata, 32'd0);
    chk("async_rst_addr", araddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(tbl[8]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
